minmax_seq: RTL and testbench

MINMAX_SEQ -- requirements
Module: minmax_seq

---
 rtl/minmax_seq.sv | 111 +++++++++++
 tb/tb_minmax_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_seq.sv
// Sequential min/max tracker: captures a frame of unsigned 8-bit samples and
// reports the largest, smallest and their difference with a one-cycle done pulse.
module minmax_seq #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [7:0]       max,
   output logic [7:0]       min,
   output logic [7:0]       diff,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [7:0]       runMax_q;
   logic [7:0]       runMin_q;
   logic [7:0]       runMax_d;
   logic [7:0]       runMin_d;
   logic [7:0]       max_q;
   logic [7:0]       min_q;
   logic [7:0]       diff_q;
   logic             accept;

   // Abort beats a coincident sample, so the sample never reaches the trackers.
   always_comb begin
      accept   = (state_q == RUN) && in_valid && !abort;
      runMax_d = (in_data > runMax_q) ? in_data : runMax_q;
      runMin_d = (in_data < runMin_q) ? in_data : runMin_q;
      count_d  = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         len_q    <= '0;
         count_q  <= '0;
         runMax_q <= 8'h00;
         runMin_q <= 8'hFF;
         max_q    <= 8'h00;
         min_q    <= 8'h00;
         diff_q   <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  count_q <= '0;
                  if (len != '0) begin
                     state_q  <= RUN;
                     len_q    <= len;
                     runMax_q <= 8'h00;
                     runMin_q <= 8'hFF;
                  end else begin
                     state_q <= DONE;
                     max_q   <= 8'h00;
                     min_q   <= 8'h00;
                     diff_q  <= 8'h00;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (accept) begin
                  runMax_q <= runMax_d;
                  runMin_q <= runMin_d;
                  count_q  <= count_d;
                  // count never exceeds len, so count_d cannot wrap here.
                  if (count_d == len_q) begin
                     state_q <= DONE;
                     max_q   <= runMax_d;
                     min_q   <= runMin_d;
                     diff_q  <= runMax_d - runMin_d;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state_q == RUN);
   assign busy     = (state_q == RUN) || (state_q == DONE);
   assign done     = (state_q == DONE);
   assign max      = max_q;
   assign min      = min_q;
   assign diff     = diff_q;
   assign count    = count_q;

endmodule

// File: tb/tb_minmax_seq.sv
// Directed bench for minmax_seq: each task drives one scenario and checks
// outputs against hand-computed values one time unit after the clock edge.
module tb_minmax_seq;

   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             abort;
   logic             inValid;
   logic [7:0]       inData;
   logic             inReady;
   logic             busy;
   logic             done;
   logic [7:0]       maxO;
   logic [7:0]       minO;
   logic [7:0]       diffO;
   logic [CNT_W-1:0] countO;

   int passCount  = 0;
   int checkCount = 0;

   minmax_seq #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .abort    (abort),
      .in_valid (inValid),
      .in_data  (inData),
      .in_ready (inReady),
      .busy     (busy),
      .done     (done),
      .max      (maxO),
      .min      (minO),
      .diff     (diffO),
      .count    (countO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; inValid = 1'b0; inData = 8'h00;
      tick();
      tick();
      checkCount++;
      if ({inReady, busy, done, maxO, minO, diffO, countO} !== 35'd0)
         $display("[TB] FAIL reset_outputs: got %h expected 0", {inReady, busy, done, maxO, minO, diffO, countO});
      else passCount++;
      rst = 1'b0;
      tick();
      checkCount++;
      if ({inReady, busy} !== 2'b00)
         $display("[TB] FAIL idle_after_reset: got ready/busy %b expected 00", {inReady, busy});
      else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] samples [4];
      samples[0] = 8'h10; samples[1] = 8'h80; samples[2] = 8'h05; samples[3] = 8'h40;
      start = 1'b1; len = 8'd4;
      tick();
      start = 1'b0;
      checkCount++;
      if ({inReady, busy, done} !== 3'b110)
         $display("[TB] FAIL b2b_run_entry: got ready/busy/done %b expected 110", {inReady, busy, done});
      else passCount++;
      for (int i = 0; i < 4; i++) begin
         inValid = 1'b1; inData = samples[i];
         tick();
      end
      inValid = 1'b0;
      checkCount++;
      if ({done, maxO, minO, diffO, countO} !== {1'b1, 8'h80, 8'h05, 8'h7B, 8'd4})
         $display("[TB] FAIL b2b_result: got done/max/min/diff/count %h expected 1_80_05_7b_04", {done, maxO, minO, diffO, countO});
      else passCount++;
      tick();
      checkCount++;
      if ({done, busy, countO, maxO} !== {1'b0, 1'b0, 8'd4, 8'h80})
         $display("[TB] FAIL b2b_hold: got done/busy/count/max %h expected 0_0_04_80", {done, busy, countO, maxO});
      else passCount++;
   endtask

   task automatic test_gaps();
      logic [7:0] samples [3];
      int doneSeen;
      int readyLow;
      samples[0] = 8'hFF; samples[1] = 8'h00; samples[2] = 8'h7F;
      doneSeen = 0; readyLow = 0;
      start = 1'b1; len = 8'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         inValid = 1'b0; inData = 8'hEE;
         for (int g = 0; g < 2; g++) begin
            if (!inReady) readyLow++;
            tick();
            if (done) doneSeen++;
         end
         if (!inReady) readyLow++;
         inValid = 1'b1; inData = samples[i];
         tick();
         if (done) doneSeen++;
      end
      inValid = 1'b0;
      checkCount++;
      if ({maxO, minO, diffO, countO} !== {8'hFF, 8'h00, 8'hFF, 8'd3})
         $display("[TB] FAIL gap_result: got max/min/diff/count %h expected ff_00_ff_03", {maxO, minO, diffO, countO});
      else passCount++;
      checkCount++;
      if (readyLow !== 0)
         $display("[TB] FAIL gap_ready: got %0d cycles with in_ready low in RUN, expected 0", readyLow);
      else passCount++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) doneSeen++;
      end
      checkCount++;
      if (doneSeen !== 1)
         $display("[TB] FAIL gap_done_once: got %0d done pulses expected 1", doneSeen);
      else passCount++;
   endtask

   task automatic test_len_one_and_zero();
      start = 1'b1; len = 8'd1;
      tick();
      start = 1'b0; inValid = 1'b1; inData = 8'h33;
      tick();
      inValid = 1'b0;
      checkCount++;
      if ({done, maxO, minO, diffO, countO} !== {1'b1, 8'h33, 8'h33, 8'h00, 8'd1})
         $display("[TB] FAIL len1_result: got %h expected 1_33_33_00_01", {done, maxO, minO, diffO, countO});
      else passCount++;
      tick();
      start = 1'b1; len = 8'd0;
      tick();
      start = 1'b0;
      checkCount++;
      if ({done, busy, inReady, maxO, minO, diffO, countO} !== {3'b110, 32'd0})
         $display("[TB] FAIL len0_result: got %h expected 6_00000000", {done, busy, inReady, maxO, minO, diffO, countO});
      else passCount++;
      tick();
      checkCount++;
      if ({done, busy} !== 2'b00)
         $display("[TB] FAIL len0_return_idle: got done/busy %b expected 00", {done, busy});
      else passCount++;
   endtask

   task automatic test_abort();
      logic [7:0] samples [3];
      int doneSeen;
      samples[0] = 8'h11; samples[1] = 8'h22; samples[2] = 8'h01;
      doneSeen = 0;
      start = 1'b1; len = 8'd2;
      tick();
      start = 1'b0; inValid = 1'b1; inData = 8'h20;
      tick();
      inData = 8'h60;
      tick();
      inValid = 1'b0;
      tick();
      start = 1'b1; len = 8'd5;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         inValid = 1'b1; inData = samples[i]; abort = (i == 2);
         tick();
         if (done) doneSeen++;
      end
      inValid = 1'b0; abort = 1'b0;
      checkCount++;
      if ({busy, done, countO} !== {2'b00, 8'd2})
         $display("[TB] FAIL abort_state: got busy/done/count %h expected 0_0_02", {busy, done, countO});
      else passCount++;
      checkCount++;
      if ({maxO, minO, diffO} !== {8'h60, 8'h20, 8'h40})
         $display("[TB] FAIL abort_results_kept: got max/min/diff %h expected 60_20_40", {maxO, minO, diffO});
      else passCount++;
      tick();
      if (done) doneSeen++;
      checkCount++;
      if (doneSeen !== 0)
         $display("[TB] FAIL abort_no_done: got %0d done pulses expected 0", doneSeen);
      else passCount++;
   endtask

   task automatic test_async_reset();
      start = 1'b1; len = 8'd3;
      tick();
      start = 1'b0; inValid = 1'b1; inData = 8'h44;
      tick();
      inValid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkCount++;
      if ({inReady, busy, done, maxO, minO, diffO, countO} !== 35'd0)
         $display("[TB] FAIL async_reset: got %h expected 0", {inReady, busy, done, maxO, minO, diffO, countO});
      else passCount++;
      #1 rst = 1'b0;
      start = 1'b1; len = 8'd2;
      tick();
      start = 1'b0;
      checkCount++;
      if (inReady !== 1'b1)
         $display("[TB] FAIL start_after_reset: got in_ready %b expected 1", inReady);
      else passCount++;
      inValid = 1'b1; inData = 8'h09;
      tick();
      tick();
      inValid = 1'b0;
      checkCount++;
      if ({done, maxO, minO, diffO, countO} !== {1'b1, 8'h09, 8'h09, 8'h00, 8'd2})
         $display("[TB] FAIL tie_result: got %h expected 1_09_09_00_02", {done, maxO, minO, diffO, countO});
      else passCount++;
      tick();
   endtask

   task automatic test_start_held();
      inValid = 1'b1; inData = 8'hAA;
      tick();
      tick();
      checkCount++;
      if ({inReady, busy, countO, maxO} !== {2'b00, 8'd2, 8'h09})
         $display("[TB] FAIL idle_valid_ignored: got ready/busy/count/max %h expected 0_0_02_09", {inReady, busy, countO, maxO});
      else passCount++;
      inValid = 1'b0;
      start = 1'b1; len = 8'd2;
      tick();
      inValid = 1'b1; inData = 8'h01; len = 8'd7;
      tick();
      inData = 8'h02;
      tick();
      inValid = 1'b0;
      checkCount++;
      if ({done, maxO, minO, diffO, countO} !== {1'b1, 8'h02, 8'h01, 8'h01, 8'd2})
         $display("[TB] FAIL start_held_result: got %h expected 1_02_01_01_02", {done, maxO, minO, diffO, countO});
      else passCount++;
      tick();
      checkCount++;
      if ({busy, done} !== 2'b00)
         $display("[TB] FAIL no_restart_in_done: got busy/done %b expected 00", {busy, done});
      else passCount++;
      tick();
      start = 1'b0;
      checkCount++;
      if ({busy, inReady, countO} !== {2'b11, 8'd0})
         $display("[TB] FAIL restart_from_idle: got busy/ready/count %h expected 1_1_00", {busy, inReady, countO});
      else passCount++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_full_len();
      start = 1'b1; len = 8'hFF;
      tick();
      start = 1'b0;
      for (int i = 0; i < 255; i++) begin
         inValid = 1'b1; inData = 8'(i + 1);
         tick();
      end
      inValid = 1'b0;
      checkCount++;
      if ({done, maxO, minO, diffO, countO} !== {1'b1, 8'hFF, 8'h01, 8'hFE, 8'hFF})
         $display("[TB] FAIL full_len_result: got %h expected 1_ff_01_fe_ff", {done, maxO, minO, diffO, countO});
      else passCount++;
      tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_len_one_and_zero();
      test_abort();
      test_async_reset();
      test_start_held();
      test_full_len();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
